// File: rtl/twofish_pkg.sv
// Shared definitions for the Twofish g-function scheduler: state encoding,
// requester tags and word width.
`default_nettype none

package twofish_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/g_rr_arb.sv
// ============================================================================
// Module   : g_rr_arb
// Brief    : 2-way round-robin arbiter; A wins the first tie after reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module g_rr_arb
    import twofish_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_a_valid,
    input  logic i_b_valid,
    input  logic i_free,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    logic r_last;
    logic w_a_wins;

    // A wins when alone, or on a tie when B held the previous grant.
    always_comb begin
        w_a_wins = i_a_valid & (~i_b_valid | (r_last == REQ_B));
        o_gnt_a  = i_free & w_a_wins;
        o_gnt_b  = i_free & i_b_valid & ~w_a_wins;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= REQ_B;
        end else if (o_gnt_a) begin
            r_last <= REQ_A;
        end else if (o_gnt_b) begin
            r_last <= REQ_B;
        end
    end

endmodule

`default_nettype wire

// File: rtl/g_sched.sv
// ============================================================================
// Module   : g_sched
// Brief    : Time-shares one combinational Twofish g datapath between the
//            T0 (A) and T1 (B) requesters. Optional macro G_SCHED_ROL8_EN
//            rotates B left by 8 before it reaches the datapath. W must be 32.
// Revision : 1.0
// ============================================================================
`default_nettype none

module g_sched
    import twofish_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    input  logic [W-1:0] a_x,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_x,
    output logic         b_ready,
    output logic [W-1:0] g_x,
    input  logic [W-1:0] g_z,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_z,
    input  logic         rsp_ready
);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic         w_free;
    logic         w_gnt_a;
    logic         w_gnt_b;
    logic         w_grant;
    logic [W-1:0] w_b_word;

    logic [W-1:0] r_g_x;
    logic         r_id;
    logic [W-1:0] r_rsp_z;
    logic         r_rsp_id;
    logic         r_rsp_valid;

`ifdef G_SCHED_ROL8_EN
    assign w_b_word = {b_x[W-9:0], b_x[W-1:W-8]};
`else
    assign w_b_word = b_x;
`endif

    // Gating with rst_n keeps both readies low while reset is asserted.
    assign w_free  = rst_n & ((r_state == ST_IDLE) |
                              ((r_state == ST_RESP) & rsp_ready));
    assign w_grant = w_gnt_a | w_gnt_b;

    g_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_a_valid (a_valid),
        .i_b_valid (b_valid),
        .i_free    (w_free),
        .o_gnt_a   (w_gnt_a),
        .o_gnt_b   (w_gnt_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = w_grant ? ST_BUSY : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A grant out of RESP overlaps the result leaving, so there is no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_g_x       <= '0;
            r_id        <= REQ_A;
            r_rsp_z     <= '0;
            r_rsp_id    <= REQ_A;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_grant) begin
                r_g_x <= w_gnt_b ? w_b_word : a_x;
                r_id  <= w_gnt_b ? REQ_B : REQ_A;
            end
            if (r_state == ST_BUSY) begin
                r_rsp_z     <= g_z;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end else if ((r_state == ST_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign a_ready   = w_gnt_a;
    assign b_ready   = w_gnt_b;
    assign g_x       = r_g_x;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_z     = r_rsp_z;

endmodule

`default_nettype wire

// File: tb/tb_g_sched.sv
// Self-checking bench for g_sched: directed scenarios plus a randomized run
// against a transaction-level reference model.
`default_nettype none

module tb_g_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, rsp_ready;
    logic [31:0] a_x, b_x;
    logic        a_ready, b_ready, rsp_valid, rsp_id;
    logic [31:0] g_x, g_z, rsp_z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in for the S-box/MDS datapath: any fixed combinational function.
    function automatic logic [31:0] gmodel(input logic [31:0] x);
        return ({x[26:0], x[31:27]} ^ 32'hC3A59E37) + {24'd0, x[7:0]};
    endfunction

    function automatic logic [31:0] bword(input logic [31:0] x);
`ifdef G_SCHED_ROL8_EN
        return {x[23:0], x[31:24]};
`else
        return x;
`endif
    endfunction

    assign g_z = gmodel(g_x);

    g_sched #(.W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_x       (a_x),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_x       (b_x),
        .b_ready   (b_ready),
        .g_x       (g_x),
        .g_z       (g_z),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_ready (rsp_ready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b1;
        a_x = 32'h0; b_x = 32'h0;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; rsp_ready = 1'b1;
        a_x = 32'hDEADBEEF; b_x = 32'hCAFEF00D;
        cyc(); cyc();
        checks++; if (g_x !== 32'h0) begin failures++; $display("FAIL reset_g_x got=%h exp=0", g_x); end
        checks++; if (rsp_z !== 32'h0) begin failures++; $display("FAIL reset_rsp_z got=%h exp=0", rsp_z); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
        checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL reset_b_ready got=%b exp=0", b_ready); end
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_a();
        do_reset();
        a_valid = 1'b1; a_x = 32'h0; rsp_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL single_a_ready got=%b exp=1", a_ready); end
        checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL single_b_ready got=%b exp=0", b_ready); end
        cyc();
        a_valid = 1'b0;
        #1;
        checks++; if (g_x !== 32'h0) begin failures++; $display("FAIL single_g_x got=%h exp=0", g_x); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", rsp_valid); end
        cyc();
        #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL single_rsp_id got=%b exp=0", rsp_id); end
        checks++; if (rsp_z !== gmodel(32'h0)) begin failures++; $display("FAIL single_rsp_z got=%h exp=%h", rsp_z, gmodel(32'h0)); end
        cyc();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_tie();
        logic [31:0] pend_x;
        logic        pend_id;
        logic        ea, eb, erv;
        do_reset();
        pend_x = 32'h0; pend_id = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; rsp_ready = 1'b1;
        a_x = $urandom; b_x = $urandom;
        for (int c = 0; c < 12; c++) begin
            #1;
            ea  = (c % 4 == 0);
            eb  = (c % 4 == 2);
            erv = (c >= 2) && (c % 2 == 0);
            checks++; if (a_ready !== ea) begin failures++; $display("FAIL tie_a_ready c=%0d got=%b exp=%b", c, a_ready, ea); end
            checks++; if (b_ready !== eb) begin failures++; $display("FAIL tie_b_ready c=%0d got=%b exp=%b", c, b_ready, eb); end
            checks++; if (rsp_valid !== erv) begin failures++; $display("FAIL tie_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, erv); end
            if (erv) begin
                checks++; if (rsp_id !== pend_id) begin failures++; $display("FAIL tie_rsp_id c=%0d got=%b exp=%b", c, rsp_id, pend_id); end
                checks++; if (rsp_z !== gmodel(pend_x)) begin failures++; $display("FAIL tie_rsp_z c=%0d got=%h exp=%h", c, rsp_z, gmodel(pend_x)); end
            end
            if (c % 2 == 1) begin
                checks++; if (g_x !== pend_x) begin failures++; $display("FAIL tie_g_x c=%0d got=%h exp=%h", c, g_x, pend_x); end
            end
            if (ea) begin pend_x = a_x; pend_id = 1'b0; end
            if (eb) begin pend_x = bword(b_x); pend_id = 1'b1; end
            cyc();
            if (ea) a_x = $urandom;
            if (eb) b_x = $urandom;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_back_pressure();
        logic [31:0] ax0;
        do_reset();
        rsp_ready = 1'b1; a_valid = 1'b1; a_x = $urandom; ax0 = a_x;
        #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL bp_a_grant got=%b exp=1", a_ready); end
        cyc();
        a_valid = 1'b0; b_valid = 1'b1; b_x = $urandom;
        #1;
        checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL bp_b_busy got=%b exp=0", b_ready); end
        cyc();
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid k=%0d got=%b exp=1", k, rsp_valid); end
            checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL bp_rsp_id k=%0d got=%b exp=0", k, rsp_id); end
            checks++; if (rsp_z !== gmodel(ax0)) begin failures++; $display("FAIL bp_rsp_z k=%0d got=%h exp=%h", k, rsp_z, gmodel(ax0)); end
            checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL bp_b_stall k=%0d got=%b exp=0", k, b_ready); end
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL bp_b_release got=%b exp=1", b_ready); end
        cyc();
        b_valid = 1'b0;
        #1;
        checks++; if (g_x !== bword(b_x)) begin failures++; $display("FAIL bp_g_x got=%h exp=%h", g_x, bword(b_x)); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_busy_valid got=%b exp=0", rsp_valid); end
        cyc();
        #1;
        checks++; if (rsp_id !== 1'b1) begin failures++; $display("FAIL bp_b_rsp_id got=%b exp=1", rsp_id); end
        checks++; if (rsp_z !== gmodel(bword(b_x))) begin failures++; $display("FAIL bp_b_rsp_z got=%h exp=%h", rsp_z, gmodel(bword(b_x))); end
        cyc();
    endtask

    task automatic test_rol8();
        logic [31:0] exp_gx;
`ifdef G_SCHED_ROL8_EN
        exp_gx = 32'h22334411;
`else
        exp_gx = 32'h11223344;
`endif
        do_reset();
        b_valid = 1'b1; b_x = 32'h11223344;
        #1;
        checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL rol8_b_ready got=%b exp=1", b_ready); end
        cyc();
        b_valid = 1'b0;
        #1;
        checks++; if (g_x !== exp_gx) begin failures++; $display("FAIL rol8_g_x got=%h exp=%h", g_x, exp_gx); end
        cyc();
        #1;
        checks++; if (rsp_z !== gmodel(exp_gx)) begin failures++; $display("FAIL rol8_rsp_z got=%h exp=%h", rsp_z, gmodel(exp_gx)); end
        cyc();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        a_valid = 1'b1; a_x = $urandom;
        cyc();
        a_valid = 1'b0; rst_n = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_in_reset got=%b exp=0", a_ready); end
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_rsp k=%0d got=%b exp=0", k, rsp_valid); end
            cyc();
        end
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL mid_tie_a got=%b exp=1", a_ready); end
        checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL mid_tie_b got=%b exp=0", b_ready); end
        cyc();
        a_valid = 1'b0; b_valid = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_fall_through();
        logic [31:0] w1;
        do_reset();
        a_valid = 1'b1; a_x = $urandom;
        cyc();
        w1 = $urandom; a_x = w1;
        #1;
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL ft_busy_ready got=%b exp=0", a_ready); end
        cyc();
        #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL ft_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL ft_same_cycle_grant got=%b exp=1", a_ready); end
        cyc();
        a_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL ft_busy_valid got=%b exp=0", rsp_valid); end
        checks++; if (g_x !== w1) begin failures++; $display("FAIL ft_g_x got=%h exp=%h", g_x, w1); end
        cyc();
        #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL ft_no_bubble got=%b exp=1", rsp_valid); end
        checks++; if (rsp_z !== gmodel(w1)) begin failures++; $display("FAIL ft_rsp_z got=%h exp=%h", rsp_z, gmodel(w1)); end
        cyc();
    endtask

    // Transaction model: slot phase (0 idle, 1 computing, 2 result held),
    // who was granted last, the word in flight and the held result.
    task automatic test_random();
        int          ph;
        logic        b_last;
        logic [31:0] fl_x, rs_z;
        logic        fl_id, rs_id;
        logic        free, ea, eb;
        do_reset();
        ph = 0; b_last = 1'b1; fl_x = 32'h0; fl_id = 1'b0; rs_z = 32'h0; rs_id = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            free = (ph == 0) || ((ph == 2) && rsp_ready);
            ea   = free && a_valid && (!b_valid || b_last);
            eb   = free && b_valid && !ea;
            checks++; if (a_ready !== ea) begin failures++; $display("FAIL rnd_a_ready n=%0d got=%b exp=%b", n, a_ready, ea); end
            checks++; if (b_ready !== eb) begin failures++; $display("FAIL rnd_b_ready n=%0d got=%b exp=%b", n, b_ready, eb); end
            checks++; if (rsp_valid !== (ph == 2)) begin failures++; $display("FAIL rnd_rsp_valid n=%0d got=%b exp=%b", n, rsp_valid, (ph == 2)); end
            if (ph == 2) begin
                checks++; if (rsp_id !== rs_id) begin failures++; $display("FAIL rnd_rsp_id n=%0d got=%b exp=%b", n, rsp_id, rs_id); end
                checks++; if (rsp_z !== rs_z) begin failures++; $display("FAIL rnd_rsp_z n=%0d got=%h exp=%h", n, rsp_z, rs_z); end
            end
            if (ph == 1) begin
                checks++; if (g_x !== fl_x) begin failures++; $display("FAIL rnd_g_x n=%0d got=%h exp=%h", n, g_x, fl_x); end
            end
            if (ea || eb) begin
                fl_x = ea ? a_x : bword(b_x); fl_id = eb; b_last = eb; ph = 1;
            end else if (ph == 1) begin
                rs_z = gmodel(fl_x); rs_id = fl_id; ph = 2;
            end else if ((ph == 2) && rsp_ready) begin
                ph = 0;
            end
            cyc();
            if (ea || !a_valid) begin a_valid = 1'($urandom_range(0, 1)); a_x = $urandom; end
            if (eb || !b_valid) begin b_valid = 1'($urandom_range(0, 1)); b_x = $urandom; end
        end
        a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b1;
        cyc(); cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_tie();
        test_back_pressure();
        test_rol8();
        test_reset_midflight();
        test_fall_through();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
